// File: rtl/mem_bus_defs.sv
// Shared definitions for the L2<->memory bus responder: bus widths and FSM state encoding.
package mem_bus_defs;
   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 64;
   localparam int WORD_LSB = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } busState_t;
endpackage

// File: rtl/mem_word_array.sv
// Word storage for the memory responder: 64-bit words, combinational read, synchronous write.
module mem_word_array
   import mem_bus_defs::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [DATA_W-1:0]     rdata
);
   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/mem_bus_responder.sv
// Main-memory responder: answers each L2 line fill / write-back with a fixed-latency,
// critical-word-first burst of BEATS 64-bit beats, one stb per beat.
module mem_bus_responder
   import mem_bus_defs::*;
#(
   parameter int LATENCY    = 4,
   parameter int BEATS      = 4,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              addrstb,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              stb,
   output logic              busy,
   output logic              err
);
   localparam int         BEAT_W   = $clog2(BEATS);
   localparam int         LINE_W   = DEPTH_LOG2 - BEAT_W;
   localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

   busState_t             state;
   logic [3:0]            latCnt;
   logic [BEAT_W-1:0]     beatCnt;
   logic [BEAT_W-1:0]     beatIdx;
   logic [BEAT_W-1:0]     beatNext;
   logic [LINE_W-1:0]     lineReg;
   logic                  weReg;
   logic [DEPTH_LOG2-1:0] reqWord;
   logic [DEPTH_LOG2-1:0] rdAddr;
   logic [DEPTH_LOG2-1:0] wrAddr;
   logic [DATA_W-1:0]     rdData;
   logic                  wrEn;
   logic                  unusedAddrBits;

   assign reqWord        = addr[DEPTH_LOG2+WORD_LSB-1:WORD_LSB];
   assign unusedAddrBits = ^{addr[ADDR_W-1:DEPTH_LOG2+WORD_LSB], addr[WORD_LSB-1:0]};
   assign beatNext       = beatIdx + BEAT_W'(1);
   assign wrAddr         = {lineReg, beatIdx};
   assign wrEn           = (state == BURST) && weReg;

   // Read address looks one beat ahead so data_out can be registered into the stb cycle.
   always_comb begin
      rdAddr = {lineReg, beatIdx};
      case (state)
         IDLE:    rdAddr = reqWord;
         BURST:   rdAddr = {lineReg, beatNext};
         default: rdAddr = {lineReg, beatIdx};
      endcase
   end

   mem_word_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) wordArray (
      .clk  (clk),
      .we   (wrEn),
      .waddr(wrAddr),
      .wdata(data_in),
      .raddr(rdAddr),
      .rdata(rdData)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         latCnt   <= '0;
         beatCnt  <= '0;
         beatIdx  <= '0;
         lineReg  <= '0;
         weReg    <= 1'b0;
         data_out <= '0;
         data_oe  <= 1'b0;
         stb      <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         err <= addrstb && (state != IDLE);
         case (state)
            IDLE: begin
               if (addrstb) begin
                  weReg   <= we;
                  lineReg <= reqWord[DEPTH_LOG2-1:BEAT_W];
                  beatIdx <= reqWord[BEAT_W-1:0];
                  beatCnt <= '0;
                  latCnt  <= LAT_INIT;
                  busy    <= 1'b1;
                  if (LATENCY == 1) begin
                     state    <= BURST;
                     stb      <= 1'b1;
                     data_oe  <= !we;
                     data_out <= we ? '0 : rdData;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               // Leaving at 1 puts the first stb exactly LATENCY cycles after acceptance.
               if (latCnt == 4'd1) begin
                  state    <= BURST;
                  stb      <= 1'b1;
                  data_oe  <= !weReg;
                  data_out <= weReg ? '0 : rdData;
               end else begin
                  latCnt <= latCnt - 4'd1;
               end
            end
            BURST: begin
               if (beatCnt == BEAT_W'(BEATS - 1)) begin
                  state    <= IDLE;
                  stb      <= 1'b0;
                  busy     <= 1'b0;
                  data_oe  <= 1'b0;
                  data_out <= '0;
               end else begin
                  beatCnt  <= beatCnt + BEAT_W'(1);
                  beatIdx  <= beatNext;
                  data_out <= weReg ? '0 : rdData;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed vector table plus randomized bursts
// checked cycle by cycle against a word-level memory model.
module tb_mem_bus_responder;
   localparam int L = 4;
   localparam int B = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        addrstb = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [63:0] data_in = '0;
   logic [63:0] data_out;
   logic        data_oe;
   logic        stb;
   logic        busy;
   logic        err;

   always #5 clk = ~clk;

   mem_bus_responder #(
      .LATENCY(L),
      .BEATS(B),
      .DEPTH_LOG2(10)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .addrstb (addrstb),
      .we      (we),
      .addr    (addr),
      .data_in (data_in),
      .data_out(data_out),
      .data_oe (data_oe),
      .stb     (stb),
      .busy    (busy),
      .err     (err)
   );

   int          vecs = 0;
   int          miscompares = 0;
   logic [63:0] refMem [1024];

   typedef struct {
      bit              wr;
      logic [31:0]     a;
      logic [3:0][63:0] dv;
      int              overlap;
      int              rstBeat;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Word touched by beat k: same line as the request, offset wraps modulo B.
   function automatic int wordOf(input logic [31:0] a, input int k);
      int w;
      w = int'(a[12:3]);
      return (w & ~(B - 1)) | ((w + k) % B);
   endfunction

   task automatic burst(input bit wr, input logic [31:0] a, input logic [3:0][63:0] dv,
                        input bit useDv, input int overlap, input int rstBeat, input string tag);
      int          k;
      bit          expStb;
      bit          expErr;
      logic [63:0] expData;
      check({tag, " idle busy"}, 64'(busy), 0);
      check({tag, " idle stb"}, 64'(stb), 0);
      addrstb = 1'b1;
      we      = wr;
      addr    = a;
      @(posedge clk);
      #1;
      addrstb = 1'b0;
      we      = 1'($urandom);
      addr    = $urandom;
      for (int j = 1; j < L + B; j++) begin
         k       = j - L;
         expStb  = (j >= L);
         expErr  = (overlap > 0) && (j == overlap + 1);
         expData = '0;
         if (expStb && !wr) expData = useDv ? dv[k] : refMem[wordOf(a, k)];
         if (expStb && (rstBeat == k)) begin
            reset = 1'b1;
            #1;
            check({tag, " rst stb"}, 64'(stb), 0);
            check({tag, " rst busy"}, 64'(busy), 0);
            check({tag, " rst oe"}, 64'(data_oe), 0);
            check({tag, " rst data"}, data_out, 0);
            @(posedge clk);
            @(posedge clk);
            #1;
            reset = 1'b0;
            $display("txn %s: %s addr=%h reset at beat %0d", tag, wr ? "write" : "read", a, k);
            return;
         end
         check($sformatf("%s c%0d stb", tag, j), 64'(stb), 64'(expStb));
         check($sformatf("%s c%0d busy", tag, j), 64'(busy), 1);
         check($sformatf("%s c%0d oe", tag, j), 64'(data_oe), 64'(expStb && !wr));
         check($sformatf("%s c%0d data", tag, j), data_out, expData);
         check($sformatf("%s c%0d err", tag, j), 64'(err), 64'(expErr));
         if (expStb && wr) begin
            data_in = dv[k];
            refMem[wordOf(a, k)] = dv[k];
         end else begin
            data_in = {$urandom, $urandom};
         end
         if (j == overlap) begin
            addrstb = 1'b1;
            we      = 1'($urandom);
            addr    = $urandom;
         end else begin
            addrstb = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      addrstb = 1'b0;
      $display("txn %s: %s addr=%h overlap=%0d", tag, wr ? "write" : "read", a, overlap);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0][63:0] rnd;
      bit               wr;
      logic [31:0]      a;
      int               ov;

      repeat (3) @(posedge clk);
      #1;
      check("reset stb", 64'(stb), 0);
      check("reset oe", 64'(data_oe), 0);
      check("reset busy", 64'(busy), 0);
      check("reset err", 64'(err), 0);
      check("reset data", data_out, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      tbl[0] = '{1'b1, 32'h0000_0040, {64'd4, 64'd3, 64'd2, 64'd1}, 0, -1};
      tbl[1] = '{1'b0, 32'h0000_0040, {64'd4, 64'd3, 64'd2, 64'd1}, 2, -1};
      tbl[2] = '{1'b0, 32'h0000_0050, {64'd2, 64'd1, 64'd4, 64'd3}, 0, -1};
      tbl[3] = '{1'b0, 32'hFFFF_E047, {64'd4, 64'd3, 64'd2, 64'd1}, 0, -1};
      tbl[4] = '{1'b1, 32'h0000_0040, {64'hD, 64'hC, 64'hB, 64'hA}, 0, 2};
      tbl[5] = '{1'b0, 32'h0000_0040, {64'd4, 64'd3, 64'hB, 64'hA}, 0, -1};
      for (int i = 0; i < 6; i++) begin
         burst(tbl[i].wr, tbl[i].a, tbl[i].dv, 1'b1, tbl[i].overlap, tbl[i].rstBeat,
               $sformatf("vec%0d", i));
      end
      repeat (3) begin
         check("post idle stb", 64'(stb), 0);
         check("post idle busy", 64'(busy), 0);
         @(posedge clk);
         #1;
      end

      for (int ln = 0; ln < 8; ln++) begin
         for (int b = 0; b < B; b++) rnd[b] = {$urandom, $urandom};
         burst(1'b1, 32'(ln * 32), rnd, 1'b1, 0, -1, $sformatf("fill%0d", ln));
      end

      for (int t = 0; t < 40; t++) begin
         for (int b = 0; b < B; b++) rnd[b] = {$urandom, $urandom};
         wr = ($urandom_range(0, 2) == 0);
         a  = ($urandom & 32'hFFFF_E007) | (32'($urandom_range(0, 31)) << 3);
         ov = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, L + B - 2)) : 0;
         burst(wr, a, rnd, wr, ov, -1, $sformatf("rnd%0d", t));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end
endmodule
